// File: rtl/i2c_slave_ctrl.sv
// I2C target answering one 7-bit address: pointer byte, then 16-bit register write or read.
// Reg 0 mirrors Temp_data (read-only); regs 1..3 are writable. SDA is open-drain via Sda_oe.
`timescale 1ns/1ps
module i2c_slave_ctrl #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h48,
  parameter logic [15:0] REG1_RST   = 16'h0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Scl_in,
  input  logic        Sda_in,
  output logic        Sda_oe,
  input  logic [15:0] Temp_data,
  output logic [15:0] Reg1_q,
  output logic [15:0] Reg2_q,
  output logic [15:0] Reg3_q,
  output logic        Reg_wr,
  output logic [1:0]  Reg_addr,
  output logic        Busy
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ACK_ADDR  = 4'd2;
  localparam logic [3:0] PTR       = 4'd3;
  localparam logic [3:0] ACK_PTR   = 4'd4;
  localparam logic [3:0] WR_MSB    = 4'd5;
  localparam logic [3:0] ACK_MSB   = 4'd6;
  localparam logic [3:0] WR_LSB    = 4'd7;
  localparam logic [3:0] ACK_LSB   = 4'd8;
  localparam logic [3:0] RD_MSB    = 4'd9;
  localparam logic [3:0] MACK_MSB  = 4'd10;
  localparam logic [3:0] RD_LSB    = 4'd11;
  localparam logic [3:0] MACK_LSB  = 4'd12;
  localparam logic [3:0] WAIT_STOP = 4'd13;

  function automatic logic [3:0] ack_next(input logic [3:0] st, input logic rw);
    case (st)
      ACK_ADDR: ack_next = rw ? RD_MSB : PTR;
      ACK_PTR:  ack_next = WR_MSB;
      ACK_MSB:  ack_next = WR_LSB;
      default:  ack_next = WAIT_STOP;
    endcase
  endfunction

  logic [2:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [3:0]  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_in_q, shift_in_d;
  logic [15:0] shift_out_q, shift_out_d;
  logic [7:0]  msb_q, msb_d;
  logic [1:0]  ptr_q, ptr_d, reg_addr_q, reg_addr_d;
  logic        sda_oe_q, sda_oe_d, busy_q, busy_d, reg_wr_q, reg_wr_d;
  logic [15:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic [15:0] rd_word_s;
  logic [7:0]  byte_in_s;
  logic        scl_rise_s, scl_fall_s, sda_bit_s, start_s, stop_s;
  logic        counting_s, byte_done_s;

  assign scl_rise_s  = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall_s  = ~scl_sync_q[1] & scl_sync_q[2];
  assign sda_bit_s   = sda_sync_q[1];
  // Bus conditions only count while SCL has been stable high for two samples.
  assign start_s     = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[1] & sda_sync_q[2];
  assign stop_s      = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[1] & ~sda_sync_q[2];
  assign byte_in_s   = {shift_in_q, sda_bit_s};
  assign counting_s  = scl_rise_s & ((state_q == ADDR) || (state_q == PTR) ||
                       (state_q == WR_MSB) || (state_q == WR_LSB) ||
                       (state_q == RD_MSB) || (state_q == RD_LSB));
  assign byte_done_s = counting_s & (bit_cnt_q == 3'd7);

  // Input synchronisers plus one extra stage for edge detection.
  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], Scl_in};
    sda_sync_d = {sda_sync_q[1:0], Sda_in};
  end

  // Word returned by a read of the current pointer.
  always_comb begin
    case (ptr_q)
      2'd1:    rd_word_s = r1_q;
      2'd2:    rd_word_s = r2_q;
      2'd3:    rd_word_s = r3_q;
      default: rd_word_s = Temp_data;
    endcase
  end

  // Transaction state machine and register-file next state.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    msb_d       = msb_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    r3_d        = r3_q;
    reg_wr_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    if (counting_s) begin
      shift_in_d = byte_in_s[6:0];
      bit_cnt_d  = bit_cnt_q + 3'd1;
    end else begin
      bit_cnt_d  = bit_cnt_q;
    end
    if (start_s) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_s) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        ADDR: begin
          if (byte_done_s && (byte_in_s[7:1] == SLAVE_ADDR)) begin
            state_d = ACK_ADDR;
            busy_d  = 1'b1;
          end else if (byte_done_s) begin
            state_d = WAIT_STOP;
            busy_d  = 1'b0;
          end else begin
            state_d = ADDR;
          end
        end
        PTR: begin
          if (byte_done_s && (byte_in_s[7:2] != 6'd0)) begin
            state_d = WAIT_STOP;
            busy_d  = 1'b0;
          end else if (byte_done_s) begin
            ptr_d   = byte_in_s[1:0];
            state_d = ACK_PTR;
          end else begin
            state_d = PTR;
          end
        end
        WR_MSB: begin
          if (byte_done_s) begin
            msb_d   = byte_in_s;
            state_d = ACK_MSB;
          end else begin
            state_d = WR_MSB;
          end
        end
        WR_LSB: begin
          if (byte_done_s) begin
            state_d    = ACK_LSB;
            reg_wr_d   = (ptr_q != 2'd0);
            reg_addr_d = ptr_q;
            case (ptr_q)
              2'd1:    r1_d = {msb_q, byte_in_s};
              2'd2:    r2_d = {msb_q, byte_in_s};
              2'd3:    r3_d = {msb_q, byte_in_s};
              default: r1_d = r1_q;
            endcase
          end else begin
            state_d = WR_LSB;
          end
        end
        // First fall pulls SDA for the ack; the next fall ends it. A read starts its MSB there.
        ACK_ADDR, ACK_PTR, ACK_MSB, ACK_LSB: begin
          if (scl_fall_s && !sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (scl_fall_s) begin
            state_d = ack_next(state_q, shift_in_q[0]);
            if ((state_q == ACK_ADDR) && shift_in_q[0]) begin
              sda_oe_d    = ~rd_word_s[15];
              shift_out_d = {rd_word_s[14:0], 1'b0};
            end else begin
              sda_oe_d    = 1'b0;
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        RD_MSB, RD_LSB: begin
          if (scl_fall_s) begin
            sda_oe_d    = ~shift_out_q[15];
            shift_out_d = {shift_out_q[14:0], 1'b0};
          end else if (byte_done_s) begin
            state_d = (state_q == RD_MSB) ? MACK_MSB : MACK_LSB;
          end else begin
            state_d = state_q;
          end
        end
        MACK_MSB, MACK_LSB: begin
          if (scl_fall_s) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise_s && sda_bit_s) begin
            state_d = WAIT_STOP;
            busy_d  = 1'b0;
          end else if (scl_rise_s && (state_q == MACK_MSB)) begin
            state_d = RD_LSB;
          end else if (scl_rise_s) begin
            state_d     = RD_MSB;
            shift_out_d = rd_word_s;
          end else begin
            state_d = state_q;
          end
        end
        WAIT_STOP: begin
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // State registers; synchronisers reset to the idle-high bus level.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      scl_sync_q  <= 3'b111;
      sda_sync_q  <= 3'b111;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 7'd0;
      shift_out_q <= 16'd0;
      msb_q       <= 8'd0;
      ptr_q       <= 2'd0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      r1_q        <= REG1_RST;
      r2_q        <= 16'd0;
      r3_q        <= 16'd0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= 2'd0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      msb_q       <= msb_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
    end
  end

  assign Sda_oe   = sda_oe_q;
  assign Busy     = busy_q;
  assign Reg1_q   = r1_q;
  assign Reg2_q   = r2_q;
  assign Reg3_q   = r3_q;
  assign Reg_wr   = reg_wr_q;
  assign Reg_addr = reg_addr_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Scoreboarded bench for i2c_slave_ctrl: a bus master model issues directed transactions,
// a monitor compares slave acks, read bytes and register-write pulses against expectations.
`timescale 1ns/1ps
module tb_i2c_slave_ctrl;

  localparam logic [15:0] R1_RST = 16'hBEEF;
  localparam int Q = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [15:0] temp = 16'h0000;
  logic        sda_oe, reg_wr, busy, sda_bus;
  logic [15:0] r1, r2, r3;
  logic [1:0]  reg_addr;

  int tests = 0;
  int fails = 0;
  int oe_count = 0;
  int oe_snap;

  logic [7:0]  exp_q[$];
  string       name_q[$];
  logic [7:0]  obs_q[$];
  logic [17:0] wr_exp_q[$];
  string       wr_name_q[$];

  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h48), .REG1_RST(R1_RST)) dut (
    .Clk(clk), .Rst(rst_n), .Scl_in(scl), .Sda_in(sda_bus), .Sda_oe(sda_oe),
    .Temp_data(temp), .Reg1_q(r1), .Reg2_q(r2), .Reg3_q(r3),
    .Reg_wr(reg_wr), .Reg_addr(reg_addr), .Busy(busy)
  );

  task automatic check1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clk_bit(input logic b, output logic r);
    m_sda = b;
    #(Q) scl = 1'b1;
    #(Q) r = sda_bus;
    #(Q) scl = 1'b0;
    #(Q);
  endtask

  task automatic start_c();
    m_sda = 1'b1;
    #(Q) scl = 1'b1;
    #(Q) m_sda = 1'b0;
    #(Q) scl = 1'b0;
    #(Q);
  endtask

  task automatic stop_c();
    m_sda = 1'b0;
    #(Q) scl = 1'b1;
    #(Q) m_sda = 1'b1;
    #(2*Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic r;
    exp_q.push_back({7'd0, exp_ack});
    name_q.push_back(nm);
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, r);
    obs_q.push_back({7'd0, r});
  endtask

  task automatic rd_byte(input logic nack, input logic [7:0] expb, input string nm);
    logic [7:0] v;
    logic r;
    exp_q.push_back(expb);
    name_q.push_back(nm);
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      v[i] = r;
    end
    clk_bit(nack, r);
    obs_q.push_back(v);
  endtask

  task automatic exp_write(input logic [1:0] a, input logic [15:0] d, input string nm);
    wr_exp_q.push_back({a, d});
    wr_name_q.push_back(nm);
  endtask

  task automatic monitor();
    logic [17:0] act;
    logic [17:0] e;
    logic [15:0] rv;
    logic [7:0]  o;
    logic [7:0]  x;
    string       nm;
    forever begin
      @(negedge clk);
      if (sda_oe === 1'b1) oe_count++;
      if (reg_wr === 1'b1) begin
        case (reg_addr)
          2'd1:    rv = r1;
          2'd2:    rv = r2;
          2'd3:    rv = r3;
          default: rv = 16'h0000;
        endcase
        act = {reg_addr, rv};
        tests++;
        if (wr_exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: got addr %0d data %h, none expected", reg_addr, rv);
        end else begin
          e  = wr_exp_q.pop_front();
          nm = wr_name_q.pop_front();
          if (act !== e) begin
            fails++;
            $display("FAIL %s: got addr %0d data %h expected addr %0d data %h",
                     nm, act[17:16], act[15:0], e[17:16], e[15:0]);
          end
        end
      end
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_bus_item: got %h", o);
        end else begin
          x  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (o !== x) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, o, x);
          end
        end
      end
    end
  endtask

  initial begin
    logic r;
    fork
      monitor();
    join_none
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Reset state
    check1("rst_sda_oe", sda_oe, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_reg_wr", reg_wr, 1'b0);
    check16("rst_reg1", r1, R1_RST);
    check16("rst_reg2", r2, 16'h0000);
    check16("rst_reg3", r3, 16'h0000);

    // Write reg 1 = ABCD
    start_c();
    wr_byte(8'h90, 1'b0, "w1_addr_ack");
    check1("w1_busy_after_match", busy, 1'b1);
    exp_write(2'd1, 16'hABCD, "w1_reg_write");
    wr_byte(8'h01, 1'b0, "w1_ptr_ack");
    wr_byte(8'hAB, 1'b0, "w1_msb_ack");
    wr_byte(8'hCD, 1'b0, "w1_lsb_ack");
    stop_c();
    check16("w1_reg1", r1, 16'hABCD);
    check1("w1_busy_after_stop", busy, 1'b0);

    // Pointer 0 then read Temp_data, changing it between bytes
    start_c();
    wr_byte(8'h90, 1'b0, "p0_addr_ack");
    wr_byte(8'h00, 1'b0, "p0_ptr_ack");
    stop_c();
    temp = 16'h1234;
    start_c();
    wr_byte(8'h91, 1'b0, "rd0_addr_ack");
    rd_byte(1'b0, 8'h12, "rd0_msb");
    temp = 16'hFFFF;
    rd_byte(1'b1, 8'h34, "rd0_lsb_snapshot");
    check1("rd0_released", sda_oe, 1'b0);
    stop_c();

    // Foreign address: never acked, never busy
    oe_snap = oe_count;
    start_c();
    wr_byte(8'h92, 1'b1, "na_addr_nack");
    wr_byte(8'h01, 1'b1, "na_b1_nack");
    wr_byte(8'h11, 1'b1, "na_b2_nack");
    wr_byte(8'h22, 1'b1, "na_b3_nack");
    check1("na_busy", busy, 1'b0);
    stop_c();
    check1("na_sda_never_driven", (oe_count == oe_snap), 1'b1);

    // Out-of-range pointer NACKed; pointer stays 0 (Temp_data)
    start_c();
    wr_byte(8'h90, 1'b0, "bp_addr_ack");
    wr_byte(8'h07, 1'b1, "bp_ptr_nack");
    stop_c();
    temp = 16'h0F0E;
    start_c();
    wr_byte(8'h91, 1'b0, "bp_rd_addr_ack");
    rd_byte(1'b1, 8'h0F, "bp_rd_ptr_kept");
    stop_c();

    // Reg 2 write, then MSB-only write aborted by STOP, then read back
    start_c();
    wr_byte(8'h90, 1'b0, "w2_addr_ack");
    exp_write(2'd2, 16'h1357, "w2_reg_write");
    wr_byte(8'h02, 1'b0, "w2_ptr_ack");
    wr_byte(8'h13, 1'b0, "w2_msb_ack");
    wr_byte(8'h57, 1'b0, "w2_lsb_ack");
    stop_c();
    start_c();
    wr_byte(8'h90, 1'b0, "ab_addr_ack");
    wr_byte(8'h02, 1'b0, "ab_ptr_ack");
    wr_byte(8'h55, 1'b0, "ab_msb_ack");
    stop_c();
    check16("ab_reg2_unchanged", r2, 16'h1357);
    start_c();
    wr_byte(8'h91, 1'b0, "ab_rd_addr_ack");
    rd_byte(1'b0, 8'h13, "ab_rd_msb");
    rd_byte(1'b1, 8'h57, "ab_rd_lsb");
    stop_c();

    // Write to read-only reg 0 is acked but discarded; extra byte NACKed
    start_c();
    wr_byte(8'h90, 1'b0, "r0_addr_ack");
    wr_byte(8'h00, 1'b0, "r0_ptr_ack");
    wr_byte(8'h11, 1'b0, "r0_msb_ack");
    wr_byte(8'h22, 1'b0, "r0_lsb_ack");
    wr_byte(8'h33, 1'b1, "r0_extra_nack");
    stop_c();
    check16("r0_reg1_kept", r1, 16'hABCD);

    // Reg 3 write, then a read with master ACK on LSB re-reads the same register
    start_c();
    wr_byte(8'h90, 1'b0, "w3_addr_ack");
    exp_write(2'd3, 16'hC3A5, "w3_reg_write");
    wr_byte(8'h03, 1'b0, "w3_ptr_ack");
    wr_byte(8'hC3, 1'b0, "w3_msb_ack");
    wr_byte(8'hA5, 1'b0, "w3_lsb_ack");
    stop_c();
    start_c();
    wr_byte(8'h91, 1'b0, "rr_addr_ack");
    rd_byte(1'b0, 8'hC3, "rr_msb_1");
    rd_byte(1'b0, 8'hA5, "rr_lsb_1");
    rd_byte(1'b0, 8'hC3, "rr_msb_2");
    rd_byte(1'b1, 8'hA5, "rr_lsb_2");
    stop_c();

    // Reset while driving a read bit low
    start_c();
    wr_byte(8'h90, 1'b0, "rs_addr_ack");
    wr_byte(8'h01, 1'b0, "rs_ptr_ack");
    stop_c();
    start_c();
    wr_byte(8'h91, 1'b0, "rs_rd_addr_ack");
    clk_bit(1'b1, r);
    check1("rs_first_bit", r, 1'b1);
    check1("rs_driving_low", sda_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("rs_sda_released", sda_oe, 1'b0);
    check16("rs_reg1_reset", r1, R1_RST);
    check16("rs_reg3_reset", r3, 16'h0000);
    check1("rs_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    stop_c();
    temp = 16'hA55A;
    start_c();
    wr_byte(8'h91, 1'b0, "rs_after_addr_ack");
    rd_byte(1'b1, 8'hA5, "rs_after_ptr_reset");
    stop_c();

    repeat (20) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL bus_items_pending: got %0d left expected 0", exp_q.size());
    end
    tests++;
    if (wr_exp_q.size() != 0) begin
      fails++;
      $display("FAIL writes_pending: got %0d left expected 0", wr_exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
